// File: rtl/isb_pkg.sv
// Shared types and sizing for the instruction-stream prefetcher and its
// issue queue: address width, queue depth, queue entry layout and the
// issue FSM state encoding.
package isb_pkg;

    localparam int ADDR_W   = 16;
    localparam int PQ_DEPTH = 4;

    // One queue slot. A squashed entry still occupies its slot until the
    // issue FSM reaches it and retires it without a memory request.
    typedef struct packed {
        logic              valid;
        logic              squashed;
        logic [ADDR_W-1:0] addr;
    } pq_entry_t;

    typedef enum logic [1:0] {
        PQ_IDLE  = 2'd0,
        PQ_REQ   = 2'd1,
        PQ_ACKED = 2'd2
    } pq_state_e;

endpackage

// File: rtl/pq_match.sv
// Combinational address CAM over the issue-queue entries. A hit means the
// slot is valid and its address equals addr_i; the caller decides whether
// squashed slots count.
module pq_match
    import isb_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH
) (
    input  pq_entry_t [DEPTH-1:0] entries_i,
    input  logic [ADDR_W-1:0]     addr_i,
    output logic [DEPTH-1:0]      hit_o
);

    // Per-slot compare of the probe address against every live slot.
    always_comb begin
        hit_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_o[i] = entries_i[i].valid && (entries_i[i].addr == addr_i);
        end
    end

endmodule

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: filters prefetch candidates (full queue, duplicate
// of a live or in-flight address, or same-cycle demand hit), buffers the
// survivors in a circular FIFO and issues them one at a time to memory
// through a REQ/ACK handshake. Demands squash matching queued candidates.
module prefetch_issue_queue
    import isb_pkg::*;
#(
    parameter int ADDR_W = isb_pkg::ADDR_W,
    parameter int DEPTH  = PQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pf_v,
    input  logic [ADDR_W-1:0]        pf_addr,
    input  logic                     dm_v,
    input  logic [ADDR_W-1:0]        dm_addr,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    pq_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [IDX_W:0]        head_q, head_d;
    logic [IDX_W:0]        tail_q, tail_d;
    pq_state_e             state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [7:0]            drop_q, drop_d;

    logic [IDX_W-1:0]      head_idx;
    logic [IDX_W-1:0]      tail_idx;
    logic [IDX_W:0]        occ;
    pq_entry_t             head_ent;
    logic [DEPTH-1:0]      pf_hit;
    logic [DEPTH-1:0]      dm_hit;
    logic                  live_dup;
    logic                  inflight_dup;
    logic                  demand_dup;
    logic                  full;
    logic                  drop;
    logic                  enq;
    logic                  pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign occ      = tail_q - head_q;
    assign head_ent = ent_q[head_idx];

    pq_match #(
        .DEPTH (DEPTH)
    ) u_pf_match (
        .entries_i (ent_q),
        .addr_i    (pf_addr),
        .hit_o     (pf_hit)
    );

    pq_match #(
        .DEPTH (DEPTH)
    ) u_dm_match (
        .entries_i (ent_q),
        .addr_i    (dm_addr),
        .hit_o     (dm_hit)
    );

    // Candidate filter: only live (unsquashed) entries and the outstanding
    // request suppress a duplicate; fullness uses the registered occupancy.
    always_comb begin
        live_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pf_hit[i] && !ent_q[i].squashed) begin
                live_dup = 1'b1;
            end
        end
        inflight_dup = mem_req_q && (mem_addr_q == pf_addr);
        demand_dup   = dm_v && (dm_addr == pf_addr);
        full         = (occ == FULL_CNT);
        drop         = pf_v && (full || live_dup || inflight_dup || demand_dup);
        enq          = pf_v && !drop;
        drop_d       = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // Issue FSM: decide whether the head is issued, silently retired or
    // waited on, and drive the registered request outputs.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pop        = 1'b0;
        unique case (state_q)
            PQ_IDLE: begin
                if (head_ent.valid) begin
                    if (head_ent.squashed) begin
                        pop = 1'b1;
                    end else begin
                        state_d    = PQ_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = head_ent.addr;
                    end
                end
            end
            PQ_REQ: begin
                if (mem_ack) begin
                    pop       = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = PQ_ACKED;
                end
            end
            PQ_ACKED: begin
                state_d = PQ_IDLE;
            end
            default: begin
                state_d   = PQ_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Queue storage update: demand squash, head retire and tail write. The
    // entry currently on the memory bus is immune to squash.
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        if (dm_v) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dm_hit[i] && !((state_q == PQ_REQ) && (IDX_W'(i) == head_idx))) begin
                    ent_d[i].squashed = 1'b1;
                end
            end
        end
        if (pop) begin
            ent_d[head_idx].valid    = 1'b0;
            ent_d[head_idx].squashed = 1'b0;
            head_d                   = head_q + 1'b1;
        end
        if (enq) begin
            ent_d[tail_idx].valid    = 1'b1;
            ent_d[tail_idx].squashed = 1'b0;
            ent_d[tail_idx].addr     = pf_addr;
            tail_d                   = tail_q + 1'b1;
        end
    end

    // State registers; reset abandons any outstanding request without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            state_q    <= PQ_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            drop_q     <= '0;
        end else begin
            ent_q      <= ent_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            drop_q     <= drop_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign count    = occ;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Testbench for prefetch_issue_queue: directed table, hand-written corner
// sequences and randomized traffic against a queue-level reference model.
module tb_prefetch_issue_queue;

    localparam int AW = 16;
    localparam int DP = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          pf_v    = 1'b0;
    logic [AW-1:0] pf_addr = '0;
    logic          dm_v    = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic          mem_ack = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [2:0]    count;
    logic [7:0]    drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prefetch_issue_queue #(
        .ADDR_W (AW),
        .DEPTH  (DP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pf_v     (pf_v),
        .pf_addr  (pf_addr),
        .dm_v     (dm_v),
        .dm_addr  (dm_addr),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic          pv;
        logic [AW-1:0] pa;
        logic          dv;
        logic [AW-1:0] da;
        logic          ack;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic [2:0]    exp_cnt;
        logic [7:0]    exp_drop;
    } vec_t;

    vec_t          tbl [13];
    logic [AW-1:0] issued [$];

    // Reference model state: ordered list of queued candidates.
    logic [AW-1:0] mq_addr [$];
    bit            mq_sq   [$];
    int            m_phase;          // 0 waiting, 1 requesting, 2 bubble
    bit            m_req;
    logic [AW-1:0] m_addr;
    int            m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_rec();
        if (mem_req && mem_ack) issued.push_back(mem_addr);
        step();
    endtask

    task automatic set_in(input logic pv, input logic [AW-1:0] pa, input logic dv,
                          input logic [AW-1:0] da, input logic ack);
        pf_v = pv; pf_addr = pa; dm_v = dv; dm_addr = da; mem_ack = ack;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_count", count, 0);
        check("reset_req", mem_req, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issued.delete();
        mq_addr.delete();
        mq_sq.delete();
        m_phase = 0;
        m_req   = 1'b0;
        m_addr  = '0;
        m_drop  = 0;
    endtask

    // One clock edge of the reference model, from the inputs applied before it.
    task automatic model_step(input logic pv, input logic [AW-1:0] pa, input logic dv,
                              input logic [AW-1:0] da, input logic ack);
        bit dup, drop, do_pop, head_sq;
        int ph0;
        dup     = 1'b0;
        do_pop  = 1'b0;
        ph0     = m_phase;
        head_sq = (mq_addr.size() > 0) ? mq_sq[0] : 1'b0;
        foreach (mq_addr[i]) if (mq_addr[i] == pa && !mq_sq[i]) dup = 1'b1;
        if (m_req && m_addr == pa) dup = 1'b1;
        drop = pv && (mq_addr.size() == DP || dup || (dv && da == pa));
        if (drop && m_drop < 255) m_drop++;
        case (m_phase)
            0: if (mq_addr.size() > 0) begin
                   if (head_sq) do_pop = 1'b1;
                   else begin m_phase = 1; m_req = 1'b1; m_addr = mq_addr[0]; end
               end
            1: if (ack) begin do_pop = 1'b1; m_req = 1'b0; m_phase = 2; end
            default: m_phase = 0;
        endcase
        if (dv) foreach (mq_addr[i]) if (mq_addr[i] == da && !(ph0 == 1 && i == 0)) mq_sq[i] = 1'b1;
        if (do_pop) begin void'(mq_addr.pop_front()); void'(mq_sq.pop_front()); end
        if (pv && !drop) begin mq_addr.push_back(pa); mq_sq.push_back(1'b0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic flow, duplicate filter, in-flight duplicate, ack outside REQ.
        tbl[0]  = '{1'b1, 16'h1000, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 3'd1, 8'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1000, 3'd1, 8'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 3'd0, 8'd0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 3'd0, 8'd0};
        tbl[4]  = '{1'b1, 16'h2000, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 3'd1, 8'd0};
        tbl[5]  = '{1'b1, 16'h2000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2000, 3'd1, 8'd1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2000, 3'd1, 8'd1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 3'd0, 8'd1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 3'd0, 8'd1};
        tbl[9]  = '{1'b1, 16'h2000, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 3'd1, 8'd1};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2000, 3'd1, 8'd1};
        tbl[11] = '{1'b1, 16'h2000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2000, 3'd1, 8'd2};
        tbl[12] = '{1'b1, 16'h2100, 1'b1, 16'h2100, 1'b1, 1'b0, 16'h0000, 3'd0, 8'd3};

        #1;
        do_reset();
        for (int r = 0; r < 13; r++) begin
            set_in(tbl[r].pv, tbl[r].pa, tbl[r].dv, tbl[r].da, tbl[r].ack);
            step();
            check($sformatf("tbl%0d_req", r), mem_req, tbl[r].exp_req);
            check($sformatf("tbl%0d_count", r), count, tbl[r].exp_cnt);
            check($sformatf("tbl%0d_drop", r), drop_cnt, tbl[r].exp_drop);
            if (tbl[r].exp_req) check($sformatf("tbl%0d_addr", r), mem_addr, tbl[r].exp_addr);
        end

        // Overflow: five distinct candidates with no ack.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 16'h4000 + 16'(4 * k), 1'b0, '0, 1'b0);
            step_rec();
        end
        check("ovf_count", count, 4);
        check("ovf_drop", drop_cnt, 1);
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (20) step_rec();
        check("ovf_issued_n", issued.size(), 4);
        for (int k = 0; k < 4 && k < issued.size(); k++)
            check($sformatf("ovf_issued%0d", k), issued[k], 16'h4000 + 16'(4 * k));
        check("ovf_drain_count", count, 0);

        // Demand squash of a queued entry while the head is requesting.
        do_reset();
        set_in(1'b1, 16'h3000, 1'b0, '0, 1'b0); step_rec();
        set_in(1'b1, 16'h3004, 1'b0, '0, 1'b0); step_rec();
        check("sq_req", mem_req, 1);
        check("sq_addr", mem_addr, 16'h3000);
        set_in(1'b0, '0, 1'b1, 16'h3004, 1'b0); step_rec();
        check("sq_count", count, 2);
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (10) step_rec();
        check("sq_issued_n", issued.size(), 1);
        if (issued.size() > 0) check("sq_issued0", issued[0], 16'h3000);
        check("sq_final_count", count, 0);
        check("sq_final_req", mem_req, 0);

        // Drop-counter saturation, then a long backpressure stall.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 16'h6000 + 16'(k), 1'b0, '0, 1'b0);
            step();
        end
        for (int d = 1; d <= 300; d++) begin
            set_in(1'b1, 16'h7000 + 16'(d), 1'b0, '0, 1'b0);
            step();
            if (d == 254) check("sat_254", drop_cnt, 254);
            if (d == 255) check("sat_255", drop_cnt, 255);
        end
        check("sat_300", drop_cnt, 255);
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("bp_req%0d", c), mem_req, 1);
            check($sformatf("bp_addr%0d", c), mem_addr, 16'h6000);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("bp_ack_req", mem_req, 0);
        check("bp_ack_count", count, 3);

        // Reset asserted in the middle of an outstanding request.
        do_reset();
        set_in(1'b1, 16'h5000, 1'b0, '0, 1'b0); step();
        set_in(1'b0, '0, 1'b0, '0, 1'b0); step();
        check("rst_pre_req", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", mem_req, 0);
        check("rst_async_count", count, 0);
        check("rst_async_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("rst_late_ack_count", count, 0);
        check("rst_late_ack_req", mem_req, 0);
        repeat (3) step();
        check("rst_quiet_req", mem_req, 0);
        check("rst_quiet_count", count, 0);

        // Randomized traffic against the reference model.
        for (int blk = 0; blk < 12; blk++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                logic          pv, dv, ak;
                logic [AW-1:0] pa, da;
                pv = ($urandom % 10) < 6;
                pa = 16'h0100 + 16'(4 * $urandom_range(0, 7));
                dv = ($urandom % 10) < 2;
                da = 16'h0100 + 16'(4 * $urandom_range(0, 7));
                ak = $urandom_range(0, 1);
                set_in(pv, pa, dv, da, ak);
                model_step(pv, pa, dv, da, ak);
                step();
                check("rnd_req", mem_req, m_req);
                check("rnd_addr", mem_addr, m_addr);
                check("rnd_count", count, mq_addr.size());
                check("rnd_drop", drop_cnt, m_drop);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
